// File: rtl/odometer_bcd.sv
// Dashboard odometer: packed-BCD total and trip mileage advanced by a
// speed-dependent step on each divider tick while in the drive state.
module odometer_bcd #(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         TICK_HZ     = 2,
  parameter int         DIGITS      = 7,
  parameter int         TRIP_DIGITS = 4,
  parameter int         SATURATE    = 0,
  parameter logic [3:0] DRIVE_STATE = 4'b0100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     power_on,
  input  logic [3:0]               state,
  input  logic [1:0]               speed,
  input  logic                     trip_clr,
  output logic [4*DIGITS-1:0]      total_bcd,
  output logic [4*TRIP_DIGITS-1:0] trip_bcd,
  output logic                     tick,
  output logic                     wrapped
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  // One BCD digit plus a small carry-in; returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit(input logic [3:0] a, input logic [1:0] cin);
    logic [4:0] d;
    logic [4:0] d_adj;
    d     = {1'b0, a} + {3'b000, cin};
    d_adj = d - 5'd10;
    if (d > 5'd9) return {1'b1, d_adj[3:0]};
    else          return {1'b0, d[3:0]};
  endfunction

  function automatic logic [4*DIGITS-1:0] sat_total(input logic [4*DIGITS-1:0] sum,
                                                    input logic carry);
    logic [4*DIGITS-1:0] nines;
    for (int i = 0; i < DIGITS; i++) nines[4*i +: 4] = 4'd9;
    if (SATURATE != 0 && carry) return nines;
    else                        return sum;
  endfunction

  logic [CNT_W-1:0]         div_cnt;
  logic                     tick_int;
  logic                     inc_p0;
  logic [4*DIGITS-1:0]      total_sum_p0;
  logic [4*TRIP_DIGITS-1:0] trip_sum_p0;
  logic                     total_carry_p0;
  logic [1:0]               c_tot;
  logic [1:0]               c_trip;
  logic [4:0]               r_tot;
  logic [4:0]               r_trip;

  assign tick_int = power_on && (div_cnt == CNT_W'(DIV - 1));
  assign inc_p0   = tick_int && (state == DRIVE_STATE) && (speed != 2'd0);

  // Stage p0: digit-serial ripple add of the step into both meters
  always_comb begin
    total_sum_p0   = '0;
    trip_sum_p0    = '0;
    r_tot          = '0;
    r_trip         = '0;
    c_tot          = speed;
    c_trip         = speed;
    for (int i = 0; i < DIGITS; i++) begin
      r_tot                  = bcd_digit(total_bcd[4*i +: 4], c_tot);
      total_sum_p0[4*i +: 4] = r_tot[3:0];
      c_tot                  = {1'b0, r_tot[4]};
    end
    total_carry_p0 = c_tot[0];
    for (int i = 0; i < TRIP_DIGITS; i++) begin
      r_trip                = bcd_digit(trip_bcd[4*i +: 4], c_trip);
      trip_sum_p0[4*i +: 4] = r_trip[3:0];
      c_trip                = {1'b0, r_trip[4]};
    end
  end

  // Stage p1: registered meters and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt   <= '0;
      total_bcd <= '0;
      trip_bcd  <= '0;
      tick      <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      if (!power_on || tick_int) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      tick    <= tick_int;
      wrapped <= inc_p0 && total_carry_p0 && (SATURATE == 0);

      if (inc_p0) total_bcd <= sat_total(total_sum_p0, total_carry_p0);

      // Unpowered or cleared trip ignores any coincident increment
      if (!power_on || trip_clr) trip_bcd <= '0;
      else if (inc_p0)           trip_bcd <= trip_sum_p0;
    end
  end

endmodule

// File: doc/odometer_bcd.md
# odometer_bcd

Parametrised odometer for the car dashboard, replacing the fixed 27-bit manual-gear mileage counter. It keeps a non-volatile-style total mileage and a resettable trip mileage, both as packed BCD so the display mux consumes them directly. An internal divider generates the mileage tick. Each tick adds a speed-dependent step of 0–3 units when the gear state equals the configured drive state. The total either wraps with a pulse or saturates.

## Interface

Parameters:
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 2, mileage tick rate; DIV = CLK_HZ/TICK_HZ (integer, ≥2)
- DIGITS, 7, BCD digits of total mileage
- TRIP_DIGITS, 4, BCD digits of trip mileage (≤ DIGITS)
- SATURATE, 0, 1 = total holds at all-9s; 0 = total wraps to 0
- DRIVE_STATE, 4'b0100, gear-state code in which mileage accumulates

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- power_on  in  1  1 = vehicle powered
- state  in  4  current gear/drive state code
- speed  in  2  increment per tick, in units (0 = stationary)
- trip_clr  in  1  level; clears trip meter
- total_bcd  out  4*DIGITS  total mileage, digit 0 in bits [3:0]
- trip_bcd  out  4*TRIP_DIGITS  trip mileage, same packing
- tick  out  1  one-cycle pulse, high in the cycle after each divider rollover
- wrapped  out  1  one-cycle pulse when total wraps (SATURATE=0 only)

## Operation

- Reset (rst=0 at a clk edge): divider=0, total_bcd=0, trip_bcd=0, tick=0, wrapped=0.
- Divider:
  - Counts 0..DIV-1 while power_on=1.
  - tick_int is true when the count is DIV-1; the divider returns to 0 on that edge.
  - While power_on=0, the divider is held at 0 and no ticks occur.
- Increment condition: tick_int && power_on && state==DRIVE_STATE && speed!=0. Step = speed (1, 2 or 3).
- BCD add:
  - Performed digit-serially in combinational logic with a ripple carry.
  - Each digit stays in 0..9. Any digit that would exceed 9 subtracts 10 and carries 1 to the next digit.
  - Carry-in to digit 0 is the step; carry-in to every higher digit is 0 or 1.
- Total overflow (carry out of the top digit):
  - SATURATE=0: keep the modulo-10^DIGITS result and pulse wrapped on the following cycle, aligned with tick. Example: 9999999 + 2 gives 0000001.
  - SATURATE=1: total becomes all-9s and stays there; wrapped is never asserted.
- Trip meter:
  - Adds the same step on the same condition.
  - Always wraps modulo 10^TRIP_DIGITS and produces no pulse.
  - Trip is independent of total saturation.
- trip_clr=1: trip_bcd becomes 0 on that edge and has priority over a coincident increment. Total is unaffected.
- power_on=0:
  - Trip is cleared every cycle and total is retained.
  - On power_on going 1, the divider starts from 0, so the first tick comes DIV cycles later.
- state or speed changes take effect at the next tick only; their value is sampled on the tick_int edge.

## Timing

- All registers update on the posedge of clk; there are no other clock domains.
- Tick cadence: with power_on=1 continuously from reset release, tick_int occurs on edge DIV, 2·DIV, …
- Output latency:
  - total_bcd/trip_bcd show the new value in the cycle after the tick_int edge, the same cycle that tick=1.
  - Latency is 1 cycle from the divider rollover edge.
- tick and wrapped are registered, each exactly one cycle wide.
- Reset mid-count discards the partial divider count. Reset has priority over every other input, including trip_clr and tick_int.
- Coincident events on the same edge:
  - rst=0 wins over everything.
  - trip_clr clears trip but total still increments.
  - A power_on falling edge coinciding with tick_int produces no increment.
- Combinational BCD ripple depth is DIGITS stages; with DIGITS ≤ 8 it must close at 100 MHz.

## Test plan

All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=3, TRIP_DIGITS=2 unless noted.

- Basic count: rst released, power_on=1, state=4'b0100, speed=1 for 50 cycles → 5 ticks, total_bcd=12'h005, trip_bcd=8'h05, tick pulses 10 cycles apart.
- Step and BCD carry: preload by running to total=12'h098, then speed=3 for one tick → total=12'h101, trip carries correctly (e.g. 8'h98→8'h01, wrapping).
- Wrap vs saturate:
  - SATURATE=0, total=12'h999, speed=1 → total=12'h000 and wrapped=1 for one cycle, aligned with tick.
  - SATURATE=1, same stimulus → total stays 12'h999, wrapped=0.
- Gating: state=4'b0010 or speed=0 for 30 cycles → tick still pulses, both outputs unchanged. power_on=0 → no tick, trip=0, total retained.
- trip_clr coincident with tick at total=12'h007, trip=8'h07 → total=12'h008, trip=8'h00.
- Reset mid-operation: assert rst=0 for one cycle at divider count 6 with total=12'h042 → next cycle all outputs 0, first subsequent tick exactly 10 cycles after rst returns high.
